// File: rtl/ifm_out_fsm_if.sv
// Receive-side AXI-Stream bundle of the S2MM output FSM.
// Ports (master view): rxd_* = frame data stream toward the S2MM DMA
// channel, rxs_* = 6-word status stream; tready inputs come from the sink.
interface ifm_out_fsm_if;
  localparam int unsigned RXD_DATA_W = 64;
  localparam int unsigned RXD_KEEP_W = RXD_DATA_W / 8;
  localparam int unsigned RXS_DATA_W = 32;
  localparam int unsigned RXS_KEEP_W = RXS_DATA_W / 8;

  logic [RXD_DATA_W-1:0] rxd_tdata;
  logic [RXD_KEEP_W-1:0] rxd_tkeep;
  logic                  rxd_tvalid;
  logic                  rxd_tlast;
  logic                  rxd_tready;

  logic [RXS_DATA_W-1:0] rxs_tdata;
  logic [RXS_KEEP_W-1:0] rxs_tkeep;
  logic                  rxs_tvalid;
  logic                  rxs_tlast;
  logic                  rxs_tready;

  modport master (
    output rxd_tdata, rxd_tkeep, rxd_tvalid, rxd_tlast,
    input  rxd_tready,
    output rxs_tdata, rxs_tkeep, rxs_tvalid, rxs_tlast,
    input  rxs_tready
  );

  modport slave (
    input  rxd_tdata, rxd_tkeep, rxd_tvalid, rxd_tlast,
    output rxd_tready,
    input  rxs_tdata, rxs_tkeep, rxs_tvalid, rxs_tlast,
    output rxs_tready
  );
endinterface

// File: rtl/ifm_out_fsm.sv
// Receive output FSM: drains one frame at a time from a data FIFO and its
// matching status FIFO entry. Good frames are streamed on rxd and followed
// by a 6-word status record on rxs; bad frames (when C_DROP_BAD=1) are
// popped silently and counted.
// Ports:
//   s2mm_clk / s2mm_resetn     clock, async active-low reset
//   ctrl_fifo_*                FWFT status FIFO: [15:0] len, [16] good, [47:32] checksum
//   data_fifo_*                FWFT data FIFO: [63:0] data, [71:64] keep, [72] last
//   rx                         rxd (data) and rxs (status) AXI-Stream masters
//   rx_good_cnt / rx_drop_cnt  delivered / discarded frame counters (wrap)
//   ifm_out_fsm_dbg            one-hot state {STS, DROP, DATA, IDLE}
module ifm_out_fsm #(
  parameter bit C_DROP_BAD = 1'b1
) (
  input  logic                 s2mm_clk,
  input  logic                 s2mm_resetn,
  input  logic [63:0]          ctrl_fifo_rdata,
  input  logic                 ctrl_fifo_empty,
  output logic                 ctrl_fifo_rden,
  input  logic [72:0]          data_fifo_rdata,
  input  logic                 data_fifo_empty,
  output logic                 data_fifo_rden,
  ifm_out_fsm_if.master        rx,
  output logic [31:0]          rx_good_cnt,
  output logic [31:0]          rx_drop_cnt,
  output logic [3:0]           ifm_out_fsm_dbg
);

  localparam int unsigned LEN_W     = 16;
  localparam int unsigned CSUM_W    = 16;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned LAST_WORD = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_DROP = 2'd2,
    S_STS  = 2'd3
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    word_idx;
  logic [LEN_W-1:0]    sts_len;
  logic [CSUM_W-1:0]   sts_csum;
  logic                sts_good;

  logic                d_last;
  logic                c_good;
  logic                in_data;
  logic                in_drop;
  logic                in_sts;
  logic                data_valid;
  logic                data_hs;
  logic                drop_pop;
  logic                drop_done;
  logic                sts_hs;
  logic                last_word;
  logic                sts_done;
  logic [WORD_W-1:0]   rxs_word;
  logic                unused_ctrl;

  // Reserved status bits carry nothing for this block.
  assign unused_ctrl = ^{ctrl_fifo_rdata[63:48], ctrl_fifo_rdata[31:17]};

  // FIFO head fields and per-state handshake qualifiers.
  assign d_last     = data_fifo_rdata[72];
  assign c_good     = ctrl_fifo_rdata[16];
  assign in_data    = (state == S_DATA);
  assign in_drop    = (state == S_DROP);
  assign in_sts     = (state == S_STS);
  assign data_valid = in_data && !data_fifo_empty;
  assign data_hs    = data_valid && rx.rxd_tready;
  assign drop_pop   = in_drop && !data_fifo_empty;
  assign drop_done  = drop_pop && d_last;
  assign sts_hs     = in_sts && rx.rxs_tready;
  assign last_word  = (word_idx == IDX_W'(LAST_WORD));
  assign sts_done   = sts_hs && last_word;

  // Data stream is a straight pass-through of the FIFO head while in DATA.
  assign rx.rxd_tvalid = data_valid;
  assign rx.rxd_tdata  = in_data ? data_fifo_rdata[63:0]  : 64'h0;
  assign rx.rxd_tkeep  = in_data ? data_fifo_rdata[71:64] : 8'h0;
  assign rx.rxd_tlast  = in_data && d_last;

  // Data pops follow the rxd handshake in DATA and free-run in DROP.
  assign data_fifo_rden = data_hs || drop_pop;

  // Status entry is released only when its frame is fully retired; the
  // empty guard keeps a misbehaving FIFO from being popped while empty.
  assign ctrl_fifo_rden = (drop_done || sts_done) && !ctrl_fifo_empty;

  // Status record word selected by the word index.
  always_comb begin
    rxs_word = '0;
    case (word_idx)
      3'd0:    rxs_word = 32'h5000_0000;
      3'd4:    rxs_word = {16'h0, sts_csum};
      3'd5:    rxs_word = {15'h0, sts_good, sts_len};
      default: rxs_word = '0;
    endcase
  end

  assign rx.rxs_tvalid = in_sts;
  assign rx.rxs_tdata  = in_sts ? rxs_word : 32'h0;
  assign rx.rxs_tkeep  = in_sts ? 4'hF : 4'h0;
  assign rx.rxs_tlast  = in_sts && last_word;

  assign ifm_out_fsm_dbg = {in_sts, in_drop, in_data, (state == S_IDLE)};

  // State, word index, latched status fields and frame counters.
  always_ff @(posedge s2mm_clk or negedge s2mm_resetn) begin
    if (!s2mm_resetn) begin
      state       <= S_IDLE;
      word_idx    <= '0;
      sts_len     <= '0;
      sts_csum    <= '0;
      sts_good    <= 1'b0;
      rx_good_cnt <= '0;
      rx_drop_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!ctrl_fifo_empty) begin
            // Snapshot the status head so the record stays stable in STS.
            sts_len  <= ctrl_fifo_rdata[15:0];
            sts_csum <= ctrl_fifo_rdata[47:32];
            sts_good <= c_good;
            word_idx <= '0;
            state    <= (c_good || !C_DROP_BAD) ? S_DATA : S_DROP;
          end
        end
        S_DATA: begin
          if (data_hs && d_last) begin
            state <= S_STS;
          end
        end
        S_DROP: begin
          if (drop_done) begin
            rx_drop_cnt <= rx_drop_cnt + CNT_W'(1);
            state       <= S_IDLE;
          end
        end
        S_STS: begin
          if (sts_hs) begin
            if (last_word) begin
              word_idx    <= '0;
              rx_good_cnt <= rx_good_cnt + CNT_W'(1);
              state       <= S_IDLE;
            end else begin
              word_idx <= word_idx + IDX_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifm_out_fsm.sv
// Bench for ifm_out_fsm: FIFO contents and expected rxd/rxs traffic are
// derived from frame descriptors; DUT traffic is scored against them.
module tb_ifm_out_fsm;

  localparam bit DROP_BAD = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] ctrl_rdata;
  logic        ctrl_empty;
  logic        ctrl_rden;
  logic [72:0] data_rdata;
  logic        data_empty;
  logic        data_rden;
  logic [31:0] good_cnt;
  logic [31:0] drop_cnt;
  logic [3:0]  dbg;

  always #5 clk = ~clk;

  ifm_out_fsm_if rx();

  ifm_out_fsm #(.C_DROP_BAD(DROP_BAD)) dut (
    .s2mm_clk        (clk),
    .s2mm_resetn     (rst_n),
    .ctrl_fifo_rdata (ctrl_rdata),
    .ctrl_fifo_empty (ctrl_empty),
    .ctrl_fifo_rden  (ctrl_rden),
    .data_fifo_rdata (data_rdata),
    .data_fifo_empty (data_empty),
    .data_fifo_rden  (data_rden),
    .rx              (rx),
    .rx_good_cnt     (good_cnt),
    .rx_drop_cnt     (drop_cnt),
    .ifm_out_fsm_dbg (dbg)
  );

  // FIFO contents and expected output traffic
  logic [72:0] dq[$];
  logic [63:0] cq[$];
  logic [72:0] exp_rxd[$];
  logic [31:0] exp_rxs[$];
  logic [31:0] m_good = 0;
  logic [31:0] m_drop = 0;

  int errors = 0;
  int checks = 0;
  int data_pops = 0, ctrl_pops = 0, rxd_beats = 0, rxs_words = 0;
  int hole = 0, hole_at = -1, hole_cycles = 0;
  int rxd_mode = 0;
  bit rxs_rand = 0, stall_w2 = 0, rand_holes = 0;
  int stall_ctr = 0, stall_seen = 0;
  bit prev_rxd_stall = 0, prev_rxs_stall = 0;
  logic [72:0] prev_rxd;
  logic [31:0] prev_rxs;
  logic [31:0] last_w4, last_w5;

  task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_inputs();
    data_empty = (dq.size() == 0) || (hole > 0);
    data_rdata = (dq.size() != 0) ? dq[0] : 73'h0;
    ctrl_empty = (cq.size() == 0);
    ctrl_rdata = (cq.size() != 0) ? cq[0] : 64'h0;
  endtask

  // Frame descriptor -> FIFO entries plus expected stream traffic.
  task automatic add_frame(input int nb, input bit good, input logic [7:0] last_keep,
                           input logic [15:0] len, input logic [15:0] csum);
    logic [72:0] b;
    for (int i = 0; i < nb; i++) begin
      b[63:0]  = {$urandom, $urandom};
      b[71:64] = (i == nb - 1) ? last_keep : 8'hFF;
      b[72]    = (i == nb - 1);
      dq.push_back(b);
      if (good || !DROP_BAD) exp_rxd.push_back(b);
    end
    cq.push_back({16'h0, csum, 15'h0, good, len});
    if (good || !DROP_BAD) begin
      exp_rxs.push_back(32'h5000_0000);
      exp_rxs.push_back(32'h0);
      exp_rxs.push_back(32'h0);
      exp_rxs.push_back(32'h0);
      exp_rxs.push_back({16'h0, csum});
      exp_rxs.push_back({15'h0, good, len});
      m_good = m_good + 1;
    end else begin
      m_drop = m_drop + 1;
    end
  endtask

  // One clock: sample/score at negedge, then apply FIFO pops and new inputs.
  task automatic step();
    logic [72:0] e;
    logic [31:0] w;
    bit pop_d, pop_c;
    int pos;
    @(negedge clk);
    check("one_valid", rx.rxd_tvalid & rx.rxs_tvalid, 0);
    check("ctrl_pop_empty", ctrl_rden & ctrl_empty, 0);
    check("data_pop_empty", data_rden & data_empty, 0);
    check("dbg_onehot", $onehot(dbg), 1);
    if (rx.rxd_tvalid) check("data_rden_hs", data_rden, rx.rxd_tready);
    if (hole > 0) begin
      hole_cycles++;
      check("hole_valid", rx.rxd_tvalid, 0);
    end
    if (prev_rxd_stall) begin
      check("rxd_hold_valid", rx.rxd_tvalid, 1);
      check("rxd_hold_data", {rx.rxd_tlast, rx.rxd_tkeep, rx.rxd_tdata}, prev_rxd);
    end
    if (prev_rxs_stall) begin
      check("rxs_hold_valid", rx.rxs_tvalid, 1);
      check("rxs_hold_data", rx.rxs_tdata, prev_rxs);
    end
    prev_rxd_stall = rx.rxd_tvalid && !rx.rxd_tready;
    prev_rxd       = {rx.rxd_tlast, rx.rxd_tkeep, rx.rxd_tdata};
    prev_rxs_stall = rx.rxs_tvalid && !rx.rxs_tready;
    prev_rxs       = rx.rxs_tdata;
    if (rx.rxs_tvalid && !rx.rxs_tready && stall_w2 && (rxs_words % 6 == 2)) begin
      stall_ctr++;
      if (stall_ctr > stall_seen) stall_seen = stall_ctr;
    end
    if (rx.rxd_tvalid && rx.rxd_tready) begin
      check("rxd_queued", exp_rxd.size() != 0, 1);
      if (exp_rxd.size() != 0) begin
        e = exp_rxd.pop_front();
        check("rxd_beat", {rx.rxd_tlast, rx.rxd_tkeep, rx.rxd_tdata}, e);
      end
      rxd_beats++;
    end
    if (rx.rxs_tvalid && rx.rxs_tready) begin
      pos = rxs_words % 6;
      check("rxs_tlast", rx.rxs_tlast, pos == 5);
      check("rxs_tkeep", rx.rxs_tkeep, 4'hF);
      check("rxs_queued", exp_rxs.size() != 0, 1);
      if (exp_rxs.size() != 0) begin
        w = exp_rxs.pop_front();
        check("rxs_word", rx.rxs_tdata, w);
      end
      if (pos == 4) last_w4 = rx.rxs_tdata;
      if (pos == 5) last_w5 = rx.rxs_tdata;
      rxs_words++;
      stall_ctr = 0;
    end
    pop_d = data_rden;
    pop_c = ctrl_rden;
    @(posedge clk);
    #1;
    if (hole > 0) hole--;
    if (pop_d && dq.size() != 0) begin
      void'(dq.pop_front());
      data_pops++;
      if (data_pops == hole_at) hole = 4;
      else if (rand_holes && hole == 0 && $urandom_range(0, 7) == 0) hole = $urandom_range(1, 3);
    end
    if (pop_c && cq.size() != 0) begin
      void'(cq.pop_front());
      ctrl_pops++;
    end
    case (rxd_mode)
      1:       rx.rxd_tready = ~rx.rxd_tready;
      2:       rx.rxd_tready = ($urandom_range(0, 3) != 0);
      default: rx.rxd_tready = 1'b1;
    endcase
    if (stall_w2 && (rxs_words % 6 == 2) && stall_ctr < 5) rx.rxs_tready = 1'b0;
    else if (rxs_rand) rx.rxs_tready = ($urandom_range(0, 3) != 0);
    else rx.rxs_tready = 1'b1;
    apply_inputs();
  endtask

  task automatic drain(input string tag, input int limit);
    int n = 0;
    while ((dq.size() != 0 || cq.size() != 0 || dbg != 4'b0001) && n < limit) begin
      step();
      n++;
    end
    step();
    check({tag, "_drained"}, n < limit, 1);
    check({tag, "_rxd_left"}, exp_rxd.size(), 0);
    check({tag, "_rxs_left"}, exp_rxs.size(), 0);
    check({tag, "_good_cnt"}, good_cnt, m_good);
    check({tag, "_drop_cnt"}, drop_cnt, m_drop);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_d, b_c, b_rxd, b_rxs, b_hole, k, nb;
    rx.rxd_tready = 1'b1;
    rx.rxs_tready = 1'b1;
    apply_inputs();
    repeat (2) @(negedge clk);
    check("rst_dbg", dbg, 4'b0001);
    check("rst_good_cnt", good_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_rxd_tvalid", rx.rxd_tvalid, 0);
    check("rst_rxs_tvalid", rx.rxs_tvalid, 0);
    check("rst_ctrl_rden", ctrl_rden, 0);
    check("rst_data_rden", data_rden, 0);

    // Good 3-beat frame, length 20, checksum ABCD, queued while in reset
    add_frame(3, 1'b1, 8'h0F, 16'd20, 16'hABCD);
    apply_inputs();
    @(negedge clk);
    check("rst_hold_dbg", dbg, 4'b0001);
    rst_n = 1'b1;
    #1;
    check("rel_no_move", dbg, 4'b0001);
    @(posedge clk);
    #1;
    b_rxd = rxd_beats; b_rxs = rxs_words;
    drain("good3", 200);
    check("good3_beats", rxd_beats - b_rxd, 3);
    check("good3_words", rxs_words - b_rxs, 6);
    check("good3_w4", last_w4, 32'h0000_ABCD);
    check("good3_w5", last_w5, 32'h0001_0014);
    check("good3_cnt1", good_cnt, 1);

    // Bad 2-beat frame is dropped silently
    b_d = data_pops; b_c = ctrl_pops; b_rxd = rxd_beats; b_rxs = rxs_words;
    add_frame(2, 1'b0, 8'hFF, 16'd16, 16'h1234);
    apply_inputs();
    drain("bad2", 200);
    check("bad2_data_pops", data_pops - b_d, 2);
    check("bad2_ctrl_pops", ctrl_pops - b_c, 1);
    check("bad2_rxd", rxd_beats - b_rxd, 0);
    check("bad2_rxs", rxs_words - b_rxs, 0);
    check("bad2_drop1", drop_cnt, 1);

    // rxd_tready toggling, rxs stalled 5 cycles on w2
    rxd_mode = 1; stall_w2 = 1; stall_seen = 0;
    b_rxd = rxd_beats; b_rxs = rxs_words;
    add_frame(4, 1'b1, 8'h03, 16'd26, 16'h5A5A);
    apply_inputs();
    drain("bp", 400);
    check("bp_beats", rxd_beats - b_rxd, 4);
    check("bp_words", rxs_words - b_rxs, 6);
    check("bp_w2_stall", stall_seen, 5);
    rxd_mode = 0; stall_w2 = 0;

    // Data FIFO empty for 4 cycles after the first beat
    b_rxd = rxd_beats; b_hole = hole_cycles;
    hole_at = data_pops + 1;
    add_frame(3, 1'b1, 8'hFF, 16'd24, 16'h0F0F);
    apply_inputs();
    drain("hole", 300);
    check("hole_cycles", hole_cycles - b_hole, 4);
    check("hole_beats", rxd_beats - b_rxd, 3);
    hole_at = -1;

    // Randomised mix of good/bad frames under random back-pressure and gaps
    rxd_mode = 2; rxs_rand = 1; rand_holes = 1;
    for (int f = 0; f < 30; f++) begin
      nb = $urandom_range(1, 5);
      k  = $urandom_range(1, 8);
      add_frame(nb, $urandom_range(0, 2) != 0, 8'(8'hFF >> (8 - k)),
                16'((nb - 1) * 8 + k), 16'($urandom));
    end
    apply_inputs();
    drain("rand", 5000);
    rxd_mode = 0; rxs_rand = 0; rand_holes = 0;

    // Reset while status word 3 is presented
    add_frame(2, 1'b1, 8'hFF, 16'd16, 16'hBEEF);
    apply_inputs();
    k = 0;
    while (!(rx.rxs_tvalid && (rxs_words % 6 == 3)) && k < 200) begin
      step();
      k++;
    end
    check("rst_w3_reached", k < 200, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstw3_dbg", dbg, 4'b0001);
    check("rstw3_rxs_tvalid", rx.rxs_tvalid, 0);
    check("rstw3_rxd_tvalid", rx.rxd_tvalid, 0);
    check("rstw3_ctrl_rden", ctrl_rden, 0);
    check("rstw3_data_rden", data_rden, 0);
    check("rstw3_ctrl_kept", cq.size(), 1);
    check("rstw3_good_cnt", good_cnt, 0);
    check("rstw3_drop_cnt", drop_cnt, 0);
    dq.delete(); cq.delete(); exp_rxd.delete(); exp_rxs.delete();
    m_good = 0; m_drop = 0; rxs_words = 0; stall_ctr = 0; hole = 0;
    prev_rxd_stall = 0; prev_rxs_stall = 0;
    apply_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    add_frame(1, 1'b1, 8'h01, 16'd1, 16'h0001);
    apply_inputs();
    drain("post_rst", 200);

    // Good counter wraps from all-ones to zero
    force dut.rx_good_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.rx_good_cnt;
    m_good = 32'hFFFF_FFFF;
    check("wrap_preload", good_cnt, 32'hFFFF_FFFF);
    add_frame(2, 1'b1, 8'h0F, 16'd12, 16'h7777);
    apply_inputs();
    drain("wrap", 200);
    check("wrap_zero", good_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ifm_out_fsm.md
IFM_OUT_FSM -- requirements
Module: ifm_out_fsm

Interface
REQ-001 SHALL have parameter C_DROP_BAD, default 1, meaning 1 = discard frames with good bit clear, 0 = forward them with status.
REQ-002 SHALL have port s2mm_clk, input, 1, meaning the single clock for all logic.
REQ-003 SHALL have port s2mm_resetn, input, 1, meaning reset, asynchronous, active-low.
REQ-004 SHALL have port ctrl_fifo_rdata, input, 64, meaning status FIFO head: [15:0] byte length, [16] good, [47:32] raw checksum, rest reserved.
REQ-005 SHALL have port ctrl_fifo_empty, input, 1, meaning status FIFO empty.
REQ-006 SHALL have port ctrl_fifo_rden, output, 1, meaning pop the status FIFO head.
REQ-007 SHALL have port data_fifo_rdata, input, 73, meaning data FIFO head: [63:0] data, [71:64] keep, [72] last.
REQ-008 SHALL have port data_fifo_empty, input, 1, meaning data FIFO empty.
REQ-009 SHALL have port data_fifo_rden, output, 1, meaning pop the data FIFO head.
REQ-010 SHALL have ports rxd_tdata (output, 64), rxd_tkeep (output, 8), rxd_tvalid (output, 1), rxd_tlast (output, 1) and rxd_tready (input, 1), meaning the AXI-Stream receive data master toward the S2MM DMA channel.
REQ-011 SHALL have ports rxs_tdata (output, 32), rxs_tkeep (output, 4), rxs_tvalid (output, 1), rxs_tlast (output, 1) and rxs_tready (input, 1), meaning the AXI-Stream receive status master.
REQ-012 SHALL have port rx_good_cnt, output, 32, meaning the count of frames delivered.
REQ-013 SHALL have port rx_drop_cnt, output, 32, meaning the count of frames discarded.
REQ-014 SHALL have port ifm_out_fsm_dbg, output, 4, meaning the one-hot current state {STS,DROP,DATA,IDLE}.

Function
REQ-015 SHALL treat both FIFOs as first-word-fall-through: rdata is valid whenever empty=0, and a rden pulse pops exactly one entry.
REQ-016 SHALL rely on one status entry existing per complete frame in the data FIFO, written after that frame's last beat.
REQ-017 SHALL implement the states IDLE, DATA, DROP and STS.
REQ-018 SHALL, in IDLE with ctrl_fifo_empty=0, move next cycle to DATA if good=1 or C_DROP_BAD=0, otherwise to DROP; with ctrl_fifo_empty=1 it SHALL stay in IDLE.
REQ-019 SHALL, in DATA, drive rxd_tvalid = !data_fifo_empty, drive rxd_tdata, rxd_tkeep and rxd_tlast directly from the data FIFO head, and drive data_fifo_rden = rxd_tvalid & rxd_tready.
REQ-020 SHALL, in DATA, go to STS on the handshake of a beat with last=1, and SHALL pop no data after that beat.
REQ-021 SHALL keep rxd payload stable under back-pressure; no data_fifo_rden while rxd_tready=0.
REQ-022 SHALL, in DROP, keep rxd_tvalid=0 and drive data_fifo_rden = !data_fifo_empty.
REQ-023 SHALL, in DROP, on the pop of a last=1 beat: pulse ctrl_fifo_rden for one cycle, increment rx_drop_cnt and return to IDLE.
REQ-024 SHALL, in STS, emit exactly 6 words under a 3-bit word index 0..5, with rxs_tvalid=1 and rxs_tkeep=4'hF.
REQ-025 SHALL make the STS words: w0=32'h5000_0000; w1=w2=w3=0; w4={16'h0, checksum}; w5={15'h0, good, length}.
REQ-026 SHALL assert rxs_tlast only on w5, and SHALL advance the word index only on rxs_tvalid & rxs_tready.
REQ-027 SHALL, on the w5 handshake: pulse ctrl_fifo_rden for one cycle, increment rx_good_cnt and return to IDLE.
REQ-028 SHALL make rx_good_cnt and rx_drop_cnt wrap modulo 2^32.
REQ-029 SHALL assert ctrl_fifo_rden only in the cycles given in REQ-023 and REQ-027, and never while ctrl_fifo_empty=1.
REQ-030 SHALL never assert rxd_tvalid and rxs_tvalid in the same cycle.
REQ-031 SHALL never return to IDLE before the status entry is popped, so back-to-back frames need at least one IDLE cycle between them.

Reset
REQ-032 SHALL, while s2mm_resetn=0, force: state IDLE, word index 0, both counters 0, all tvalid/rden low, ifm_out_fsm_dbg=4'b0001.
REQ-033 SHALL, on reset mid-frame, abandon the frame without popping any FIFO entry; FIFO flushing is owned by the FIFO's own reset.
REQ-034 SHALL make the first transition occur no earlier than the first s2mm_clk edge after deassertion.

Verification
REQ-035 SHALL cover: good frame of 3 beats (last keep 8'h0F), length 20, checksum 16'hABCD, tready=1 -> 3 rxd beats then 6 rxs words, w4=32'h0000ABCD, w5=32'h0001_0014, rx_good_cnt=1.
REQ-036 SHALL cover: bad frame of 2 beats with C_DROP_BAD=1 -> no rxd or rxs activity, 2 data pops, 1 ctrl pop, rx_drop_cnt=1.
REQ-037 SHALL cover: rxd_tready toggled every cycle, and rxs_tready held low 5 cycles on w2 -> payload stable, no lost or duplicated beat or word.
REQ-038 SHALL cover: data FIFO empty for 4 cycles mid-frame -> rxd_tvalid=0 for those cycles, frame then completes intact.
REQ-039 SHALL cover: s2mm_resetn asserted during STS w3 -> all outputs at reset values next edge, no ctrl pop, counters 0.
REQ-040 SHALL cover: rx_good_cnt preloaded via force to 32'hFFFF_FFFF, one good frame -> rx_good_cnt=0.
